// File: rtl/matrix_row_loader_if.sv
// Sample stream, control and storage-write signals of one matrix_row_loader.
// The loader connects through the slave modport; the feeder/storage side uses master.
interface matrix_row_loader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 3,
    parameter int INDEX_WIDTH = 32
);
    logic                          start;
    logic                          in_valid;
    logic signed [DATA_WIDTH-1:0]  in_data;
    logic                          in_ready;
    logic [DATA_WIDTH*LANES-1:0]   write_data;
    logic [INDEX_WIDTH-1:0]        write_layer_index;
    logic [INDEX_WIDTH-1:0]        write_row_index;
    logic                          is_write;
    logic                          busy;
    logic                          done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, write_data, write_layer_index, write_row_index,
               is_write, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, write_data, write_layer_index, write_row_index,
               is_write, busy, done
    );
endinterface

// File: rtl/matrix_row_loader.sv
// Packs LANES serial samples per storage row and walks row/layer indices for a full matrix load.
// Optional integer-to-fixed-point scaling of each sample is enabled by MATRIX_ROW_LOADER_SCALE_EN.
module matrix_row_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int LANES          = 3,
    parameter int INDEX_WIDTH    = 32,
    parameter int ROWS_PER_LAYER = 4,
    parameter int LAYER_COUNT    = 3,
    parameter int FRAC_BITS      = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    matrix_row_loader_if.slave bus
);
    localparam int ROW_BITS = DATA_WIDTH * LANES;
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ROW_W    = (ROWS_PER_LAYER > 1) ? $clog2(ROWS_PER_LAYER) : 1;
    localparam int LAYER_W  = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
    localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(LANES - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS_PER_LAYER - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYER_COUNT - 1);
`ifdef MATRIX_ROW_LOADER_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif
    localparam int SCALE_SHIFT = SCALE_EN ? FRAC_BITS : 0;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LANE_W-1:0]       r_lane;
    logic [ROW_W-1:0]        r_row;
    logic [LAYER_W-1:0]      r_layer;
    logic [ROW_BITS-1:0]     r_row_buf;
    logic [ROW_BITS-1:0]     r_write_data;
    logic [INDEX_WIDTH-1:0]  r_wr_layer;
    logic [INDEX_WIDTH-1:0]  r_wr_row;
    logic [ROW_BITS-1:0]     w_row_next;
    logic signed [DATA_WIDTH-1:0] w_sample;
    logic                    w_accept;
    logic                    w_last_lane;
    logic                    w_last_row;
    logic                    w_last_layer;

    // Integer-to-fixed-point conversion; the shift is zero in the pass-through build.
    function automatic logic signed [DATA_WIDTH-1:0] f_scale(input logic signed [DATA_WIDTH-1:0] x);
        f_scale = x <<< SCALE_SHIFT;
    endfunction

    assign w_sample     = f_scale(bus.in_data);
    assign w_accept     = (r_state == S_COLLECT) && bus.in_valid;
    assign w_last_lane  = (r_lane == LANE_LAST);
    assign w_last_row   = (r_row == ROW_LAST);
    assign w_last_layer = (r_layer == LAYER_LAST);

    // Sample k lands in lane k counted from the most significant end.
    always_comb begin
        w_row_next = r_row_buf;
        for (int k = 0; k < LANES; k++) begin
            if (r_lane == LANE_W'(k))
                w_row_next[(LANES-k)*DATA_WIDTH-1 -: DATA_WIDTH] = w_sample;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.is_write = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (w_accept && w_last_lane) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                bus.busy     = 1'b1;
                bus.is_write = 1'b1;
                w_state_next = (w_last_row && w_last_layer) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_lane       <= '0;
            r_row        <= '0;
            r_layer      <= '0;
            r_write_data <= '0;
            r_wr_layer   <= '0;
            r_wr_row     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lane  <= '0;
                        r_row   <= '0;
                        r_layer <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_row_buf <= w_row_next;
                        r_lane    <= w_last_lane ? '0 : r_lane + LANE_W'(1);
                        if (w_last_lane) begin
                            r_write_data <= w_row_next;
                            r_wr_layer   <= INDEX_WIDTH'(r_layer);
                            r_wr_row     <= INDEX_WIDTH'(r_row);
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_layer <= w_last_layer ? '0 : r_layer + LAYER_W'(1);
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                S_DONE: begin
                    r_wr_layer <= '0;
                    r_wr_row   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.write_data        = r_write_data;
    assign bus.write_layer_index = r_wr_layer;
    assign bus.write_row_index   = r_wr_row;
endmodule

// File: tb/tb_matrix_row_loader.sv
// Directed bench for matrix_row_loader with a 2x2 (layer x row) load of 3-lane rows.
// Expected rows follow the scaled encoding when MATRIX_ROW_LOADER_SCALE_EN is defined.
module tb_matrix_row_loader;
  localparam int DW = 16;
  localparam int L  = 3;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr     = 0;

  always #5 clk = ~clk;

  matrix_row_loader_if #(.DATA_WIDTH(DW), .LANES(L), .INDEX_WIDTH(IW)) bus ();

  matrix_row_loader #(
    .DATA_WIDTH(DW), .LANES(L), .INDEX_WIDTH(IW),
    .ROWS_PER_LAYER(2), .LAYER_COUNT(2), .FRAC_BITS(8)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus)
  );

  always @(posedge clk) if (bus.is_write === 1'b1) n_wr++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sc(input logic [15:0] x);
`ifdef MATRIX_ROW_LOADER_SCALE_EN
    return x << 8;
`else
    return x;
`endif
  endfunction

  function automatic logic [47:0] row3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {sc(a), sc(b), sc(c)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [47:0] d, input int layer, input int rw);
    chk({tag, ".is_write"}, 64'(bus.is_write), 64'd1);
    chk({tag, ".data"},     64'(bus.write_data), 64'(d));
    chk({tag, ".layer"},    64'(bus.write_layer_index), 64'(layer));
    chk({tag, ".row"},      64'(bus.write_row_index), 64'(rw));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, ".busy"},     64'(bus.busy), 64'd0);
    chk({tag, ".is_write"}, 64'(bus.is_write), 64'd0);
    chk({tag, ".done"},     64'(bus.done), 64'd0);
    chk({tag, ".data"},     64'(bus.write_data), 64'd0);
    chk({tag, ".layer"},    64'(bus.write_layer_index), 64'd0);
    chk({tag, ".row"},      64'(bus.write_row_index), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    cyc();
    bus.start = 1'b1;
    cyc();
    chk_zero("reset");
    rst = 1'b0;
    bus.start = 1'b0;
    cyc();
    chk("idle.busy", 64'(bus.busy), 64'd0);
    chk("idle.in_ready", 64'(bus.in_ready), 64'd0);

    // full load with basic, signed and backpressured rows
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("collect.busy", 64'(bus.busy), 64'd1);
    chk("collect.in_ready", 64'(bus.in_ready), 64'd1);
    push(16'h0001);
    chk("r00.lane0", 64'(bus.is_write), 64'd0);
    push(16'h0002);
    chk("r00.lane1", 64'(bus.is_write), 64'd0);
    push(16'h0003);
    chk_write("r00", row3(16'h0001, 16'h0002, 16'h0003), 0, 0);
    cyc();
    chk("r00.after", 64'(bus.is_write), 64'd0);
    chk("r00.hold", 64'(bus.write_data), 64'(row3(16'h0001, 16'h0002, 16'h0003)));
    push(16'h0003);
    push(16'hFFFF);
    push(16'h0000);
    chk_write("r01", row3(16'h0003, 16'hFFFF, 16'h0000), 0, 1);
    cyc();

    bus.in_data = 16'h0007; bus.in_valid = 1'b1; cyc();
    bus.in_valid = 1'b0; bus.in_data = 16'hAAAA; cyc();
    cyc();
    chk("bp.ready", 64'(bus.in_ready), 64'd1);
    chk("bp.nowrite", 64'(bus.is_write), 64'd0);
    bus.in_data = 16'h8000; bus.in_valid = 1'b1; cyc();
    bus.in_valid = 1'b0; bus.in_data = 16'h5555; cyc();
    chk("bp.nowrite2", 64'(bus.is_write), 64'd0);
    bus.in_data = 16'h7FFF; bus.in_valid = 1'b1; cyc();
    bus.in_valid = 1'b0;
    chk_write("r10", row3(16'h0007, 16'h8000, 16'h7FFF), 1, 0);
    cyc();
    push(16'h000A);
    push(16'h000B);
    push(16'h000C);
    chk_write("r11", row3(16'h000A, 16'h000B, 16'h000C), 1, 1);
    cyc();
    chk("done.pulse", 64'(bus.done), 64'd1);
    chk("done.busy", 64'(bus.busy), 64'd1);
    chk("done.in_ready", 64'(bus.in_ready), 64'd0);
    chk("done.is_write", 64'(bus.is_write), 64'd0);
    cyc();
    chk("end.done", 64'(bus.done), 64'd0);
    chk("end.busy", 64'(bus.busy), 64'd0);
    chk("end.layer", 64'(bus.write_layer_index), 64'd0);
    chk("end.row", 64'(bus.write_row_index), 64'd0);
    chk("end.hold", 64'(bus.write_data), 64'(row3(16'h000A, 16'h000B, 16'h000C)));
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("end.in_ready", 64'(bus.in_ready), 64'd0);
    chk("end.is_write", 64'(bus.is_write), 64'd0);

    // reset in the middle of row 1
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    push(16'h0001); push(16'h0002); push(16'h0003);
    cyc();
    push(16'h0004); push(16'h0005);
    rst = 1'b1;
    cyc();
    chk_zero("midrst");
    rst = 1'b0;
    cyc();
    chk("midrst.is_write", 64'(bus.is_write), 64'd0);
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    push(16'h0006);
    chk("midrst.idle_ready", 64'(bus.in_ready), 64'd0);

    // reload after reset, with a start pulse ignored mid-load
    n_wr = 0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    push(16'h0021);
    chk("reload.lane0", 64'(bus.is_write), 64'd0);
    push(16'h0022);
    chk("reload.lane1", 64'(bus.is_write), 64'd0);
    push(16'h0023);
    chk_write("reload.r00", row3(16'h0021, 16'h0022, 16'h0023), 0, 0);
    cyc();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("ign.busy", 64'(bus.busy), 64'd1);
    chk("ign.in_ready", 64'(bus.in_ready), 64'd1);
    push(16'h0031); push(16'h0032); push(16'h0033);
    chk_write("ign.r01", row3(16'h0031, 16'h0032, 16'h0033), 0, 1);
    cyc();
    push(16'h0041); push(16'h0042); push(16'h0043);
    chk_write("ign.r10", row3(16'h0041, 16'h0042, 16'h0043), 1, 0);
    cyc();
    push(16'h0051); push(16'h0052); push(16'h0053);
    chk_write("ign.r11", row3(16'h0051, 16'h0052, 16'h0053), 1, 1);
    cyc();
    chk("ign.done", 64'(bus.done), 64'd1);
    cyc();
    chk("ign.writes", 64'(n_wr), 64'd4);
    chk("ign.idle_busy", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_row_loader.md
Name: matrix_row_loader

Overview:
- Upstream feeder for the data_path matrix storages (weight, input and label).
- Accepts a serial stream of 16-bit samples over a valid/ready handshake.
- Packs LANES samples into one storage row and drives the storage write interface: write_data, write_layer_index, write_row_index, is_write.
- Walks row and layer indices automatically for a full matrix load, then signals done.
- One instance per storage.

Parameters:
- DATA_WIDTH, 16, width of one sample (Q8.8 fixed point).
- LANES, 3, samples per storage row; row width = DATA_WIDTH*LANES.
- INDEX_WIDTH, 32, width of layer and row index outputs.
- ROWS_PER_LAYER, 4, rows written per layer before the layer index advances.
- LAYER_COUNT, 3, layers per load.
- FRAC_BITS, 8, fractional bits used by the optional scaling.

Ports:
- clk_clk  input  1  clock; all logic on rising edge.
- reset_reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from layer 0, row 0.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  signed sample.
- in_ready  output  1  loader accepts a sample this cycle.
- write_data  output  DATA_WIDTH*LANES  packed row; sample 0 in the most significant lane.
- write_layer_index  output  INDEX_WIDTH  layer of the current write.
- write_row_index  output  INDEX_WIDTH  row of the current write.
- is_write  output  1  one-cycle write strobe to the storage.
- busy  output  1  high from start until done.
- done  output  1  one-cycle pulse after the final row is written.

Behaviour:
- Reset: synchronous, active-high; wins over every other input in the same cycle.
  - State = IDLE.
  - All outputs are 0, including write_data and both indices.
  - Lane counter, row counter and layer counter are 0.
- IDLE:
  - in_ready = 0, busy = 0.
  - start = 1 → COLLECT; row and layer counters cleared.
  - start while not in IDLE is ignored.
- COLLECT:
  - in_ready = 1, busy = 1.
  - A sample is accepted when in_valid && in_ready.
  - Accepted sample k (k = 0..LANES-1) is stored in lane bits [(LANES-k)*DATA_WIDTH-1 -: DATA_WIDTH].
  - Accepting lane LANES-1 → WRITE.
  - in_valid low: state holds; partial row retained indefinitely.
- WRITE (exactly 1 cycle):
  - is_write = 1, in_ready = 0.
  - write_data = packed row; write_layer_index and write_row_index = current counters.
  - Latency: is_write asserts the cycle after the last sample of a row is accepted.
  - Throughput: LANES+1 cycles per row at best.
- Counter advance at the end of WRITE:
  - If row == ROWS_PER_LAYER-1: row ← 0 and layer++.
  - Otherwise: row++.
  - If that row was row ROWS_PER_LAYER-1 of layer LAYER_COUNT-1 → DONE; otherwise → COLLECT.
- DONE (1 cycle):
  - done = 1, busy = 1, in_ready = 0 → IDLE.
  - Indices return to 0 in IDLE.
- Output hold: write_data and the indices hold their last values while is_write = 0. The storage must qualify them with is_write only.
- Sign: samples are treated as signed. No saturation in pass-through mode.
- Reset mid-load: the partial row is discarded, no write is issued, and done does not pulse.
- Counter widths: cover ROWS_PER_LAYER-1 and LAYER_COUNT-1; output indices are zero-extended to INDEX_WIDTH.

Optional Feature:
- Macro: MATRIX_ROW_LOADER_SCALE_EN.
- Defined:
  - Each accepted sample is treated as an integer and converted to fixed point: stored lane = in_data << FRAC_BITS, truncated to DATA_WIDTH.
  - Example: 3 → 0x0300, -1 → 0xFF00.
  - Used for the input and label storages.
- Undefined:
  - Samples are stored unmodified (raw Q8.8), as for the weight storage.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic row (ROWS_PER_LAYER=2, LAYER_COUNT=2, scaling off): start, then samples 0x0001, 0x0002, 0x0003 with in_valid held high → is_write exactly 1 cycle after the third accept, write_data=0x000100020003, layer=0, row=0.
- Full load: 12 samples streamed → four writes in the order (layer, row) = (0,0), (0,1), (1,0), (1,1); done pulses 1 cycle after the fourth write; busy falls with done; further samples are not accepted (in_ready=0).
- Backpressure: in_valid toggled 1,0,0,1,0,1 → only the asserted cycles are accepted; in_ready=0 during the WRITE cycle; packed row correct.
- Scaling (MATRIX_ROW_LOADER_SCALE_EN defined): samples 3, -1, 0 → write_data=0x0300FF000000.
- Reset mid-load: assert reset_reset after 2 samples of row 1 → all outputs 0 the next cycle, no is_write; a new start rewrites from layer 0, row 0.
- Ignored start: pulse start during COLLECT → counters unchanged, load completes normally with exactly 4 writes.
